// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, parity codes and bit-period helper used by
//                the transmitter and the matching receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_t;

    // Clock frequency is given in MHz; the result is truncated like the receiver's.
    function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
        longint l_cycles;
        l_cycles = (longint'(clk_freq) * 64'sd1_000_000) / longint'(bit_rate);
        return int'(l_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter; pulses bit_done on the last
//                cycle of every CYCLES_PER_BIT period while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 868
) (
    input  logic aclk,
    input  logic areset,
    input  logic en,
    input  logic clr,
    output logic bit_done
);

    localparam int                 c_cnt_w = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CYCLES_PER_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 2) begin : g_bad_cycles_per_bit
            $error("uart_bit_timer: CYCLES_PER_BIT must be at least 2");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;

    assign bit_done = en && (r_cnt == c_last);

    always_ff @(posedge aclk) begin
        if (areset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (bit_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_to_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : axis_to_uart_tx
//  Description : AXI-Stream slave to asynchronous UART transmitter (start,
//                LSB-first data, optional parity, 1 or 2 stop bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_to_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       TX,
    output logic       busy
);

    localparam int         c_cycles_per_bit = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam logic [2:0] c_last_bit       = 3'(BIT_PER_WORD - 1);
    localparam logic [7:0] c_data_mask      = 8'((1 << BIT_PER_WORD) - 1);

    generate
        if (PARITY_BIT < PARITY_NONE || PARITY_BIT > PARITY_EVEN) begin : g_bad_parity
            $error("axis_to_uart_tx: PARITY_BIT must be 0, 1 or 2");
        end
        if (STOP_BITS_NUM != 1 && STOP_BITS_NUM != 2) begin : g_bad_stop_bits
            $error("axis_to_uart_tx: STOP_BITS_NUM must be 1 or 2");
        end
        if (BIT_PER_WORD < 5 || BIT_PER_WORD > 8) begin : g_bad_word_len
            $error("axis_to_uart_tx: BIT_PER_WORD must be in 5..8");
        end
    endgenerate

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity;
    logic       r_tx;

    logic       w_handshake;
    logic       w_bit_done;
    logic [7:0] w_data;

    assign tready      = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign TX          = r_tx;
    assign w_handshake = tvalid && tready;
    // Unused upper bits are zeroed so they neither shift out nor affect parity.
    assign w_data      = tdata & c_data_mask;

    uart_bit_timer #(
        .CYCLES_PER_BIT (c_cycles_per_bit)
    ) u_bit_timer (
        .aclk     (aclk),
        .areset   (areset),
        .en       (busy),
        .clr      (w_handshake),
        .bit_done (w_bit_done)
    );

    // TX is decoded from the current state register, so the line trails the
    // state by one cycle; this keeps it glitch-free and every bit full length.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_handshake) begin
                        r_shift   <= w_data;
                        r_parity  <= (PARITY_BIT == PARITY_ODD) ? ~(^w_data) : ^w_data;
                        r_bit_cnt <= '0;
                        r_state   <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_bit_done) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_done) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_BIT != PARITY_NONE) ? PARITY : STOP1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    r_tx <= r_parity;
                    if (w_bit_done) begin
                        r_state <= STOP1;
                    end
                end
                STOP1: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_state <= (STOP_BITS_NUM == 2) ? STOP2 : IDLE;
                    end
                end
                STOP2: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
